// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with standard or first-word-fall-through
// read, programmable almost-full/almost-empty flags, sticky error flags and synchronous flush.
module sync_fifo_param #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AF_LVL = DEPTH - 2,
  parameter int AE_LVL = 2,
  parameter int FWFT   = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   wr_en,
  input  logic [DATA_W-1:0]      input_data,
  input  logic                   rd_en,
  output logic [DATA_W-1:0]      output_data,
  output logic                   empty,
  output logic                   full,
  output logic                   almost_empty,
  output logic                   almost_full,
  output logic [$clog2(DEPTH):0] fifo_cnt,
  output logic                   overflow,
  output logic                   underflow,
  input  logic                   err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $fatal(1, "sync_fifo_param: DEPTH must be a power of two and at least 4");
  end
  if (!((AE_LVL < AF_LVL) && (AF_LVL <= DEPTH))) begin : g_bad_levels
    $fatal(1, "sync_fifo_param: levels must satisfy AE_LVL < AF_LVL <= DEPTH");
  end
  if (DATA_W < 1) begin : g_bad_width
    $fatal(1, "sync_fifo_param: DATA_W must be at least 1");
  end

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [CW-1:0]     cnt_r;
  logic [CW-1:0]     cnt_nxt_s;
  logic              ovf_r;
  logic              unf_r;
  logic              wr_acc_s;
  logic              rd_acc_s;
  logic              ovf_set_s;
  logic              unf_set_s;

  assign empty        = (cnt_r == {CW{1'b0}});
  assign full         = (cnt_r == CW'(DEPTH));
  assign almost_empty = (cnt_r <= CW'(AE_LVL));
  assign almost_full  = (cnt_r >= CW'(AF_LVL));
  assign fifo_cnt     = cnt_r;
  assign overflow     = ovf_r;
  assign underflow    = unf_r;

  // Acceptance, next occupancy and error-set decode; flush suppresses error reporting.
  always_comb begin
    rd_acc_s  = rd_en & ~empty;
    wr_acc_s  = wr_en & (~full | rd_acc_s);
    ovf_set_s = wr_en & ~wr_acc_s & ~flush;
    unf_set_s = rd_en & empty & ~flush;
    case ({wr_acc_s, rd_acc_s})
      2'b10:   cnt_nxt_s = cnt_r + CW'(1);
      2'b01:   cnt_nxt_s = cnt_r - CW'(1);
      default: cnt_nxt_s = cnt_r;
    endcase
  end

  // Pointer and occupancy registers; flush wins over any transfer in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      cnt_r    <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      cnt_r    <= {CW{1'b0}};
    end else begin
      if (wr_acc_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (rd_acc_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      cnt_r <= cnt_nxt_s;
    end
  end

  // Sticky error flags: a new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_set_s | (ovf_r & ~err_clr);
      unf_r <= unf_set_s | (unf_r & ~err_clr);
    end
  end

  // Storage array; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (reset && wr_acc_s && !flush) mem_r[wr_ptr_r] <= input_data;
  end

  if (FWFT != 0) begin : g_fwft
    // Head word is presented directly; an empty FIFO drives zero.
    always_comb begin
      if (empty) output_data = {DATA_W{1'b0}};
      else       output_data = mem_r[rd_ptr_r];
    end
  end else begin : g_std
    logic [DATA_W-1:0] dout_r;

    // Registered read port: updates only on an accepted read, holds otherwise.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)                 dout_r <= {DATA_W{1'b0}};
      else if (!flush && rd_acc_s) dout_r <= mem_r[rd_ptr_r];
    end

    assign output_data = dout_r;
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench: drives a standard 8x16 FIFO and an FWFT 32x8 FIFO with shared stimulus
// and checks both against queue-based reference models every cycle.
module tb_sync_fifo_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, flush, wr_en, rd_en, err_clr;
  logic [31:0] din;

  logic [7:0]  a_dout;
  logic        a_empty, a_full, a_ae, a_af, a_ovf_o, a_unf_o;
  logic [4:0]  a_cnt;
  logic [31:0] b_dout;
  logic        b_empty, b_full, b_ae, b_af, b_ovf_o, b_unf_o;
  logic [3:0]  b_cnt;

  sync_fifo_param u_std (
    .clk(clk), .reset(reset), .flush(flush), .wr_en(wr_en), .input_data(din[7:0]),
    .rd_en(rd_en), .output_data(a_dout), .empty(a_empty), .full(a_full),
    .almost_empty(a_ae), .almost_full(a_af), .fifo_cnt(a_cnt),
    .overflow(a_ovf_o), .underflow(a_unf_o), .err_clr(err_clr)
  );

  sync_fifo_param #(.DATA_W(32), .DEPTH(8), .FWFT(1)) u_fwft (
    .clk(clk), .reset(reset), .flush(flush), .wr_en(wr_en), .input_data(din),
    .rd_en(rd_en), .output_data(b_dout), .empty(b_empty), .full(b_full),
    .almost_empty(b_ae), .almost_full(b_af), .fifo_cnt(b_cnt),
    .overflow(b_ovf_o), .underflow(b_unf_o), .err_clr(err_clr)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference state: contents as plain queues, sticky flags as bits.
  logic [7:0]  qa[$];
  logic [31:0] qb[$];
  logic [7:0]  sb_a[$];
  bit a_ovf = 1'b0, a_unf = 1'b0, b_ovf = 1'b0, b_unf = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops read responses for the registered port and compares all outputs.
  initial begin
    logic [7:0] hold_a;
    hold_a = 8'h00;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (sb_a.size() > 0) hold_a = sb_a.pop_front();
        chk("std_data",  {24'h0, a_dout}, {24'h0, hold_a});
        chk("std_cnt",   {27'h0, a_cnt}, 32'(qa.size()));
        chk("std_empty", {31'h0, a_empty}, {31'h0, qa.size() == 0});
        chk("std_full",  {31'h0, a_full}, {31'h0, qa.size() == 16});
        chk("std_ae",    {31'h0, a_ae}, {31'h0, qa.size() <= 2});
        chk("std_af",    {31'h0, a_af}, {31'h0, qa.size() >= 14});
        chk("std_ovf",   {31'h0, a_ovf_o}, {31'h0, a_ovf});
        chk("std_unf",   {31'h0, a_unf_o}, {31'h0, a_unf});
        chk("fwft_data", b_dout, (qb.size() == 0) ? 32'h0 : qb[0]);
        chk("fwft_cnt",  {28'h0, b_cnt}, 32'(qb.size()));
        chk("fwft_empty", {31'h0, b_empty}, {31'h0, qb.size() == 0});
        chk("fwft_full", {31'h0, b_full}, {31'h0, qb.size() == 8});
        chk("fwft_ae",   {31'h0, b_ae}, {31'h0, qb.size() <= 2});
        chk("fwft_af",   {31'h0, b_af}, {31'h0, qb.size() >= 6});
        chk("fwft_ovf",  {31'h0, b_ovf_o}, {31'h0, b_ovf});
        chk("fwft_unf",  {31'h0, b_unf_o}, {31'h0, b_unf});
      end
    end
  end

  task automatic model_reset();
    qa.delete(); qb.delete(); sb_a.delete();
    sb_a.push_back(8'h00);
    a_ovf = 1'b0; a_unf = 1'b0; b_ovf = 1'b0; b_unf = 1'b0;
  endtask

  task automatic model_step(input bit w, input logic [31:0] d, input bit r, input bit f, input bit ec);
    bit ra, wa, os, us;
    os = 1'b0; us = 1'b0;
    if (f) qa.delete();
    else begin
      ra = r && (qa.size() > 0);
      wa = w && ((qa.size() < 16) || ra);
      os = w && !wa;
      us = r && (qa.size() == 0);
      if (ra) sb_a.push_back(qa.pop_front());
      if (wa) qa.push_back(d[7:0]);
    end
    a_ovf = (a_ovf && !ec) || os;
    a_unf = (a_unf && !ec) || us;
    os = 1'b0; us = 1'b0;
    if (f) qb.delete();
    else begin
      ra = r && (qb.size() > 0);
      wa = w && ((qb.size() < 8) || ra);
      os = w && !wa;
      us = r && (qb.size() == 0);
      if (ra) void'(qb.pop_front());
      if (wa) qb.push_back(d);
    end
    b_ovf = (b_ovf && !ec) || os;
    b_unf = (b_unf && !ec) || us;
  endtask

  task automatic drive(input bit w, input logic [31:0] d, input bit r, input bit f = 1'b0, input bit ec = 1'b0);
    wr_en = w; din = d; rd_en = r; flush = f; err_clr = ec;
    @(posedge clk);
    model_step(w, d, r, f, ec);
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; err_clr = 1'b0;
  endtask

  // Reset lands 2 time units after a rising edge and is checked before the next one.
  task automatic async_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; din = 32'h0;
    #2;
    reset = 1'b0;
    model_reset();
    chk_en = 1'b1;
    #20;
    reset = 1'b1;
    @(negedge clk);

    // Fill, overflow, drain
    for (int i = 1; i <= 16; i++) drive(1'b1, 32'(i), 1'b0);
    drive(1'b1, 32'h11, 1'b0);
    for (int i = 0; i < 16; i++) drive(1'b0, 32'h0, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

    // Pointer wrap
    for (int i = 0; i < 12; i++) drive(1'b1, $urandom, 1'b0);
    for (int i = 0; i < 12; i++) drive(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 10; i++) drive(1'b1, $urandom, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b0, 32'h0, 1'b1);

    // Simultaneous write/read when full, empty and mid-level
    for (int i = 0; i < 16; i++) drive(1'b1, 32'h40 + 32'(i), 1'b0);
    drive(1'b1, 32'h5A, 1'b1);
    for (int i = 0; i < 16; i++) drive(1'b0, 32'h0, 1'b1);
    drive(1'b1, 32'h77, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, $urandom, 1'b0);
    drive(1'b1, 32'h66, 1'b1);
    for (int i = 0; i < 5; i++) drive(1'b0, 32'h0, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

    // First-word-fall-through into an empty FIFO, then pop
    drive(1'b1, 32'hDEADBEEF, 1'b0);
    drive(1'b0, 32'h0, 1'b0);
    drive(1'b0, 32'h0, 1'b1);
    drive(1'b0, 32'h0, 1'b0);

    // Flush with a concurrent write, then error clear
    for (int i = 0; i < 9; i++) drive(1'b1, $urandom, 1'b0);
    drive(1'b1, 32'h99, 1'b0, 1'b1);
    for (int i = 0; i < 17; i++) drive(1'b1, $urandom, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b1);

    // Asynchronous reset mid-operation
    for (int i = 0; i < 7; i++) drive(1'b1, $urandom, 1'b0);
    async_reset();
    drive(1'b1, 32'hAA, 1'b0);
    drive(1'b0, 32'h0, 1'b1);
    drive(1'b0, 32'h0, 1'b0);

    // Randomised traffic: filling bias, then draining bias
    for (int i = 0; i < 600; i++) begin
      int wp, rp;
      wp = (i < 300) ? 70 : 35;
      rp = (i < 300) ? 40 : 70;
      drive($urandom_range(0, 99) < wp, $urandom, $urandom_range(0, 99) < rp,
            $urandom_range(0, 39) == 0, $urandom_range(0, 24) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
